// File: rtl/io_pkg.sv
// io_pkg: definitions shared by the host IO write port and the peripheral
// register file.
//   - wr_state_e        : write-capture FSM states
//   - IO_ADDR_*         : IO port addresses decoded by peripherals
//   - *_DEF             : default synchroniser depth and settle length
//   - addr_onehot()     : 8-bit port address to 256-bit one-hot vector
package io_pkg;

    localparam int unsigned IO_NUM_PORTS      = 256;
    localparam int unsigned SYNC_STAGES_DEF   = 2;
    localparam int unsigned SETTLE_CYCLES_DEF = 2;

    // Port map shared with the peripheral register file.
    localparam logic [7:0] IO_ADDR_LED   = 8'h38;
    localparam logic [7:0] IO_ADDR_CTRL  = 8'h3C;
    localparam logic [7:0] IO_ADDR_CFG0  = 8'hF0;
    localparam logic [7:0] IO_ADDR_CFG1  = 8'hF1;
    localparam logic [7:0] IO_ADDR_CFG2  = 8'hF2;
    localparam logic [7:0] IO_ADDR_LAST  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } wr_state_e;

    // Full 256-bit vector so that address 8'hFF maps to bit 255 without wrap.
    function automatic logic [IO_NUM_PORTS-1:0] addr_onehot(input logic [7:0] addr);
        logic [IO_NUM_PORTS-1:0] v;
        v       = {IO_NUM_PORTS{1'b0}};
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sync_bus.sv
// sync_bus: DEPTH-stage flop synchroniser for a WIDTH-bit bus.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset, loads RESET_VAL into every stage
//   d_i      : asynchronous input bus
//   q_o      : synchronised bus (output of last stage)
module sync_bus #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift chain; stage 0 samples the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q <= {stage_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/io_write_port.sv
// io_write_port: captures host IO write cycles into a 256-entry port file.
//   clk               : system clock
//   reset             : asynchronous active-low reset
//   host_iorq_n/wr_n  : host IO request / write strobes (active-low, async)
//   host_m1_n         : host M1 (low with IORQ = interrupt acknowledge)
//   host_addr/data    : host port address and data (async)
//   WRITE_PORT_DATA   : last byte written to each of the 256 ports
//   WRITE_PORT_STROBE : one-hot single-cycle pulse per accepted write
//   io_wr_busy        : FSM is not idle
module io_write_port
    import io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        host_iorq_n,
    input  logic                        host_wr_n,
    input  logic                        host_m1_n,
    input  logic [7:0]                  host_addr,
    input  logic [7:0]                  host_data,
    output logic [IO_NUM_PORTS-1:0][7:0] WRITE_PORT_DATA,
    output logic [IO_NUM_PORTS-1:0]     WRITE_PORT_STROBE,
    output logic                        io_wr_busy
);

    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

    logic [18:0] bus_s;
    logic        iorq_s, wr_s, m1_s, req_s;
    logic [7:0]  addr_s, data_s;

    wr_state_e   state_q, state_d;
    logic [7:0]  cand_addr_q, cand_addr_d;
    logic [7:0]  cand_data_q, cand_data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_en_s;

    logic [IO_NUM_PORTS-1:0][7:0] data_q;
    logic [IO_NUM_PORTS-1:0]      strobe_q;
    logic                         busy_q;

    // All host inputs share one synchroniser; strobes reset to inactive high.
    sync_bus #(
        .WIDTH     (19),
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL ({3'b111, 16'h0000})
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   ({host_iorq_n, host_wr_n, host_m1_n, host_addr, host_data}),
        .q_o   (bus_s)
    );

    assign {iorq_s, wr_s, m1_s, addr_s, data_s} = bus_s;
    // M1 high excludes interrupt acknowledge; WR low excludes IO reads.
    assign req_s = !iorq_s && !wr_s && m1_s;

    // Next-state logic: settle filter, single strobe, wait for release.
    always_comb begin
        state_d     = state_q;
        cand_addr_d = cand_addr_q;
        cand_data_d = cand_data_q;
        cnt_d       = cnt_q;
        wr_en_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    cand_addr_d = addr_s;
                    cand_data_d = data_s;
                    cnt_d       = 4'd0;
                    state_d     = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (!req_s) begin
                    state_d = IDLE;
                end else if ((addr_s != cand_addr_q) || (data_s != cand_data_q)) begin
                    // Bus still moving: restart the stability window.
                    cand_addr_d = addr_s;
                    cand_data_d = data_s;
                    cnt_d       = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if ((cnt_q + 4'd1) == SETTLE_LIM) begin
                        state_d = STROBE;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            STROBE: begin
                wr_en_s = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!req_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, candidate and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cand_addr_q <= 8'd0;
            cand_data_q <= 8'd0;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_addr_q <= cand_addr_d;
            cand_data_q <= cand_data_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // Port file and strobe: data and its strobe become visible on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q   <= {IO_NUM_PORTS{8'd0}};
            strobe_q <= {IO_NUM_PORTS{1'b0}};
        end else begin
            if (wr_en_s) begin
                data_q[cand_addr_q] <= cand_data_q;
                strobe_q            <= addr_onehot(cand_addr_q);
            end else begin
                strobe_q <= {IO_NUM_PORTS{1'b0}};
            end
        end
    end

    assign WRITE_PORT_DATA   = data_q;
    assign WRITE_PORT_STROBE = strobe_q;
    assign io_wr_busy        = busy_q;

endmodule

// File: tb/tb_io_write_port.sv
module tb_io_write_port;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  host_iorq_n = 1'b1;
    logic                  host_wr_n = 1'b1;
    logic                  host_m1_n = 1'b1;
    logic [7:0]            host_addr = 8'h00;
    logic [7:0]            host_data = 8'h00;
    logic [255:0][7:0]     WRITE_PORT_DATA;
    logic [255:0]          WRITE_PORT_STROBE;
    logic                  io_wr_busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;
    int busy_cnt = 0;
    int multi_hot = 0;
    int sq_addr[$];
    int sq_data[$];
    int sq_cyc[$];
    logic [7:0] exp_mem [256];

    // Minimum host hold (clk cycles) guaranteed to pass 2 sync + 2 settle.
    localparam int MIN_HOLD = 6;

    io_write_port #(.SYNC_STAGES(2), .SETTLE_CYCLES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .host_iorq_n       (host_iorq_n),
        .host_wr_n         (host_wr_n),
        .host_m1_n         (host_m1_n),
        .host_addr         (host_addr),
        .host_data         (host_data),
        .WRITE_PORT_DATA   (WRITE_PORT_DATA),
        .WRITE_PORT_STROBE (WRITE_PORT_STROBE),
        .io_wr_busy        (io_wr_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Observe outputs half a cycle after the active edge.
    always @(negedge clk) begin
        if (io_wr_busy === 1'b1) busy_cnt++;
        if ((|WRITE_PORT_STROBE) === 1'b1) begin
            if ($countones(WRITE_PORT_STROBE) != 1) multi_hot++;
            for (int i = 0; i < 256; i++) begin
                if (WRITE_PORT_STROBE[i] === 1'b1) begin
                    sq_addr.push_back(i);
                    sq_data.push_back(int'(WRITE_PORT_DATA[i]));
                    sq_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference rule: a host write is accepted iff it is a true write cycle
    // (WR low, M1 high) held long enough to clear synchroniser and settle.
    function automatic int model_accept(input int hold, input logic m1v, input logic wrv);
        return (wrv == 1'b0 && m1v == 1'b1 && hold >= MIN_HOLD) ? 1 : 0;
    endfunction

    task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] d,
                       input int hold, input int gap, input logic m1v, input logic wrv);
        int base, bb, t0, exp_n, lat;
        exp_n = model_accept(hold, m1v, wrv);
        base  = sq_addr.size();
        bb    = busy_cnt;
        @(posedge clk); #2;
        host_addr = a; host_data = d;
        host_iorq_n = 1'b0; host_wr_n = wrv; host_m1_n = m1v;
        t0 = cyc;
        repeat (hold) @(posedge clk);
        #2;
        host_iorq_n = 1'b1; host_wr_n = 1'b1; host_m1_n = 1'b1;
        repeat (gap) @(posedge clk);
        @(negedge clk);
        if (exp_n == 1) exp_mem[a] = d;
        chk({tag, "_strobes"}, sq_addr.size() - base, exp_n);
        if (exp_n == 1 && sq_addr.size() > base) begin
            chk({tag, "_addr"}, sq_addr[base], int'(a));
            chk({tag, "_data"}, sq_data[base], int'(d));
            lat = sq_cyc[base] - t0;
            chk({tag, "_latency_4to6"}, int'(lat >= 4 && lat <= 6), 1);
        end
        chk({tag, "_entry"}, int'(WRITE_PORT_DATA[a]), int'(exp_mem[a]));
        if (wrv == 1'b1 || m1v == 1'b0) chk({tag, "_busy_never"}, busy_cnt - bb, 0);
        chk({tag, "_idle"}, int'(io_wr_busy), 0);
    endtask

    initial begin
        int base, t0;
        logic [7:0] ra, rd;
        int kind;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobe", int'(|WRITE_PORT_STROBE), 0);
        chk("rst_data_zero", int'(WRITE_PORT_DATA == '0), 1);
        chk("rst_busy", int'(io_wr_busy), 0);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Basic write, glitch, interrupt acknowledge, IO read
        txn("w38", 8'h38, 8'h5A, 20, 6, 1'b1, 1'b0);
        txn("glitchF2", 8'hF2, 8'hC3, 1, 6, 1'b1, 1'b0);
        txn("intackF0", 8'hF0, 8'h99, 20, 6, 1'b0, 1'b0);
        txn("ioreadF0", 8'hF0, 8'h66, 20, 6, 1'b1, 1'b1);

        // Back-to-back writes to one port, three idle cycles apart
        txn("b2b_1", 8'hF1, 8'h11, MIN_HOLD, 3, 1'b1, 1'b0);
        txn("b2b_2", 8'hF1, 8'h22, MIN_HOLD, 3, 1'b1, 1'b0);
        txn("b2b_3", 8'hF1, 8'h33, MIN_HOLD, 3, 1'b1, 1'b0);
        txn("b2b_4", 8'hF1, 8'h44, MIN_HOLD, 3, 1'b1, 1'b0);

        // Data changes while settling at the top address
        base = sq_addr.size();
        @(posedge clk); #2;
        host_addr = 8'hFF; host_data = 8'h01;
        host_iorq_n = 1'b0; host_wr_n = 1'b0; host_m1_n = 1'b1;
        @(posedge clk); #2;
        host_data = 8'h02;
        repeat (15) @(posedge clk); #2;
        host_iorq_n = 1'b1; host_wr_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        exp_mem[8'hFF] = 8'h02;
        chk("chgFF_strobes", sq_addr.size() - base, 1);
        if (sq_addr.size() > base) begin
            chk("chgFF_addr", sq_addr[base], 255);
            chk("chgFF_data", sq_data[base], 2);
        end
        chk("chgFF_entry", int'(WRITE_PORT_DATA[8'hFF]), int'(exp_mem[8'hFF]));

        // Randomised traffic against the reference rule
        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 3);
            case (kind)
                0: txn("rnd_write", ra, rd, $urandom_range(MIN_HOLD, 20), 4, 1'b1, 1'b0);
                1: txn("rnd_glitch", ra, rd, 1, 4, 1'b1, 1'b0);
                2: txn("rnd_intack", ra, rd, $urandom_range(1, 20), 4, 1'b0, 1'b0);
                default: txn("rnd_read", ra, rd, $urandom_range(1, 20), 4, 1'b1, 1'b1);
            endcase
        end

        // Reset in the STROBE cycle of a write to 8'h3C
        base = sq_addr.size();
        @(posedge clk); #2;
        host_addr = 8'h3C; host_data = 8'h77;
        host_iorq_n = 1'b0; host_wr_n = 1'b0; host_m1_n = 1'b1;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        host_iorq_n = 1'b1; host_wr_n = 1'b1;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
        @(negedge clk);
        chk("rstmid_data_cleared", int'(WRITE_PORT_DATA == '0), 1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rst3C_strobes", sq_addr.size() - base, 0);
        chk("rst3C_entry", int'(WRITE_PORT_DATA[8'h3C]), 0);
        chk("rst3C_idle", int'(io_wr_busy), 0);

        // Write already in progress across a reset is accepted once afterwards
        base = sq_addr.size();
        @(posedge clk); #2;
        host_addr = 8'h55; host_data = 8'hA5;
        host_iorq_n = 1'b0; host_wr_n = 1'b0; host_m1_n = 1'b1;
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        t0 = cyc;
        repeat (15) @(posedge clk); #2;
        host_iorq_n = 1'b1; host_wr_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        exp_mem[8'h55] = 8'hA5;
        chk("inprog_strobes", sq_addr.size() - base, 1);
        if (sq_addr.size() > base) begin
            chk("inprog_data", sq_data[base], int'(8'hA5));
            chk("inprog_after_release", int'(sq_cyc[base] > t0), 1);
        end
        chk("inprog_entry", int'(WRITE_PORT_DATA[8'h55]), int'(exp_mem[8'h55]));

        chk("onehot_all_cycles", multi_hot, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
